// File: rtl/mux_gate_sched.sv
// Round-robin scheduler sharing one W-bit bank of 2:1 mux cells between N_REQ
// logic-op requesters; results return over valid/ready tagged with requester id.

module mux_gate_cell (
    input  logic i0,
    input  logic i1,
    input  logic s,
    output logic y
);
    assign y = (~s & i0) | (s & i1);
endmodule

module mux_gate_sched #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned W     = 8,
    parameter int unsigned IDW   = 2,
    parameter int unsigned CNTW  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     req,
    input  logic [3*N_REQ-1:0]   op,
    input  logic [W*N_REQ-1:0]   a,
    input  logic [W*N_REQ-1:0]   b,
    output logic [N_REQ-1:0]     gnt,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [W-1:0]         res_data,
    output logic [IDW-1:0]       res_id,
    output logic                 res_err,
    output logic [CNTW-1:0]      busy_cnt
);
    localparam int unsigned OPW = 3;

    typedef enum logic [OPW-1:0] {
        OP_AND  = 3'd0,
        OP_OR   = 3'd1,
        OP_NAND = 3'd2,
        OP_NOR  = 3'd3,
        OP_XOR  = 3'd4,
        OP_XNOR = 3'd5,
        OP_NOT  = 3'd6,
        OP_ILL  = 3'd7
    } op_e;

    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [IDW-1:0]  sel;
    logic            found;
    logic            free;
    logic [OPW-1:0]  sel_op;
    logic [W-1:0]    sel_a, sel_b;
    logic [W-1:0]    leg_i0, leg_i1, leg_s, mux_y;
    logic            res_valid_d, res_err_d;
    logic [W-1:0]    res_data_d;
    logic [IDW-1:0]  res_id_d;
    logic [CNTW-1:0] busy_cnt_d;

    function automatic int unsigned rr_idx(input logic [IDW-1:0] p, input int unsigned off);
        return (int'(p) + off) % N_REQ;
    endfunction

    // Combinational round-robin search starting at ptr; suppressed during reset
    always_comb begin
        free  = ~res_valid | res_ready;
        found = 1'b0;
        sel   = '0;
        if (rst_n && free) begin
            for (int unsigned i = 0; i < N_REQ; i++) begin
                if (!found && req[rr_idx(ptr_q, i)]) begin
                    found = 1'b1;
                    sel   = IDW'(rr_idx(ptr_q, i));
                end
            end
        end
        gnt = found ? (N_REQ'(1) << sel) : '0;
    end

    // Steer the granted requester's operands into the shared datapath
    always_comb begin
        sel_op = '0;
        sel_a  = '0;
        sel_b  = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            if (IDW'(k) == sel) begin
                sel_op = op[OPW*k +: OPW];
                sel_a  = a[W*k +: W];
                sel_b  = b[W*k +: W];
            end
        end
    end

    // Opcode to mux-leg mapping; operand A always drives the select leg
    always_comb begin
        leg_s  = sel_a;
        leg_i0 = '0;
        leg_i1 = '0;
        case (op_e'(sel_op))
            OP_AND:  begin leg_i0 = '0;     leg_i1 = sel_b;  end
            OP_OR:   begin leg_i0 = sel_b;  leg_i1 = '1;     end
            OP_NAND: begin leg_i0 = '1;     leg_i1 = ~sel_b; end
            OP_NOR:  begin leg_i0 = ~sel_b; leg_i1 = '0;     end
            OP_XOR:  begin leg_i0 = sel_b;  leg_i1 = ~sel_b; end
            OP_XNOR: begin leg_i0 = ~sel_b; leg_i1 = sel_b;  end
            OP_NOT:  begin leg_i0 = '1;     leg_i1 = '0;     end
            default: begin leg_i0 = '0;     leg_i1 = '0;     end
        endcase
    end

    for (genvar j = 0; j < W; j++) begin : g_cell
        mux_gate_cell u_cell (
            .i0 (leg_i0[j]),
            .i1 (leg_i1[j]),
            .s  (leg_s[j]),
            .y  (mux_y[j])
        );
    end

    // Next-state: a grant reloads the result slot, an accept without grant empties it
    always_comb begin
        res_valid_d = res_valid;
        res_data_d  = res_data;
        res_id_d    = res_id;
        res_err_d   = res_err;
        ptr_d       = ptr_q;
        busy_cnt_d  = busy_cnt;
        if (res_valid && res_ready) begin
            busy_cnt_d = busy_cnt + CNTW'(1);
        end
        if (found) begin
            res_valid_d = 1'b1;
            res_data_d  = (op_e'(sel_op) == OP_ILL) ? '0 : mux_y;
            res_id_d    = sel;
            res_err_d   = (op_e'(sel_op) == OP_ILL);
            ptr_d       = (sel == IDW'(N_REQ - 1)) ? '0 : sel + IDW'(1);
        end else if (res_ready) begin
            res_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q     <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_id    <= '0;
            res_err   <= 1'b0;
            busy_cnt  <= '0;
        end else begin
            ptr_q     <= ptr_d;
            res_valid <= res_valid_d;
            res_data  <= res_data_d;
            res_id    <= res_id_d;
            res_err   <= res_err_d;
            busy_cnt  <= busy_cnt_d;
        end
    end

endmodule
